// File: rtl/sim_test_monitor.sv
// End-of-test monitor: snoops per-hart register write-back ports for the completion write,
// waits a drain window, then reports pass/fail per hart, with a hard cycle timeout.
module sim_test_monitor #(
    parameter int unsigned NUM_HARTS      = 1,
    parameter int unsigned XLEN           = 32,
    parameter int unsigned DONE_REG       = 26,
    parameter int unsigned RESULT_REG     = 27,
    parameter int unsigned PASS_VAL       = 1,
    parameter int unsigned DRAIN_CYCLES   = 5,
    parameter int unsigned TIMEOUT_CYCLES = 5000,
    parameter int unsigned CNT_W          = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_HARTS-1:0]      wb_we,
    input  logic [NUM_HARTS*5-1:0]    wb_addr,
    input  logic [NUM_HARTS*XLEN-1:0] wb_data,
    output logic                      done,
    output logic                      pass,
    output logic                      fail,
    output logic                      timeout,
    output logic [NUM_HARTS-1:0]      fail_mask,
    output logic [CNT_W-1:0]          cycle_cnt
);

    localparam int unsigned DrainW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

    localparam logic [4:0]        DoneIdx     = 5'(DONE_REG);
    localparam logic [4:0]        ResultIdx   = 5'(RESULT_REG);
    localparam logic [XLEN-1:0]   PassVal     = XLEN'(PASS_VAL);
    localparam logic [XLEN-1:0]   DoneVal     = XLEN'(1);
    localparam logic [CNT_W-1:0]  TimeoutLast = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [DrainW-1:0] DrainLast   = DrainW'(DRAIN_CYCLES - 1);

    typedef enum logic [1:0] {
        StRun,
        StDrain,
        StEnd
    } state_e;

    state_e                state_q;
    logic [CNT_W-1:0]      cycle_cnt_q;
    logic [DrainW-1:0]     drain_cnt_q;
    logic [NUM_HARTS-1:0]  done_seen_q, done_seen_d;
    logic [XLEN-1:0]       result_q [NUM_HARTS];
    logic [XLEN-1:0]       result_d [NUM_HARTS];
    logic [NUM_HARTS-1:0]  res_fail;

    logic                  done_q, pass_q, fail_q, timeout_q;
    logic [NUM_HARTS-1:0]  fail_mask_q;

    logic [4:0]            hart_addr [NUM_HARTS];
    logic [XLEN-1:0]       hart_data [NUM_HARTS];

    for (genvar h = 0; h < NUM_HARTS; h++) begin : g_hart
        assign hart_addr[h] = wb_addr[5*h +: 5];
        assign hart_data[h] = wb_data[XLEN*h +: XLEN];
    end

    // Per-hart snoop; next-state values are used so same-cycle writes count immediately.
    always_comb begin
        done_seen_d = done_seen_q;
        result_d    = result_q;
        res_fail    = '0;
        for (int h = 0; h < NUM_HARTS; h++) begin
            if (state_q != StEnd && wb_we[h] && hart_addr[h] != 5'd0) begin
                if (hart_addr[h] == ResultIdx) begin
                    result_d[h] = hart_data[h];
                end
                if (state_q == StRun && hart_addr[h] == DoneIdx && hart_data[h] == DoneVal) begin
                    done_seen_d[h] = 1'b1;
                end
            end
            res_fail[h] = (result_d[h] != PassVal);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StRun;
            cycle_cnt_q <= '0;
            drain_cnt_q <= '0;
            done_seen_q <= '0;
            for (int h = 0; h < NUM_HARTS; h++) begin
                result_q[h] <= '0;
            end
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            fail_q      <= 1'b0;
            timeout_q   <= 1'b0;
            fail_mask_q <= '0;
        end else begin
            done_seen_q <= done_seen_d;
            result_q    <= result_d;
            unique case (state_q)
                StRun: begin
                    cycle_cnt_q <= cycle_cnt_q + 1'b1;
                    if (&done_seen_d) begin
                        state_q     <= StDrain;
                        drain_cnt_q <= '0;
                    end else if (cycle_cnt_q == TimeoutLast) begin
                        state_q     <= StEnd;
                        done_q      <= 1'b1;
                        pass_q      <= 1'b0;
                        fail_q      <= 1'b1;
                        timeout_q   <= 1'b1;
                        fail_mask_q <= ~done_seen_d;
                    end
                end
                StDrain: begin
                    cycle_cnt_q <= cycle_cnt_q + 1'b1;
                    drain_cnt_q <= drain_cnt_q + 1'b1;
                    if (drain_cnt_q == DrainLast) begin
                        state_q     <= StEnd;
                        done_q      <= 1'b1;
                        pass_q      <= ~|res_fail;
                        fail_q      <= |res_fail;
                        timeout_q   <= 1'b0;
                        fail_mask_q <= res_fail;
                    end
                end
                StEnd: begin
                end
                default: state_q <= StRun;
            endcase
        end
    end

    assign done      = done_q;
    assign pass      = pass_q;
    assign fail      = fail_q;
    assign timeout   = timeout_q;
    assign fail_mask = fail_mask_q;
    assign cycle_cnt = cycle_cnt_q;

endmodule

// File: tb/tb_sim_test_monitor.sv
// Directed bench for sim_test_monitor: three instances cover single-hart, dual-hart and
// short-timeout configurations; cycle numbers count from the first cycle after reset release.
module tb_sim_test_monitor;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;
    int unsigned cyc      = 0;

    // Instance A: one hart, defaults
    logic        rst_a = 1'b1;
    logic [0:0]  we_a = '0;
    logic [4:0]  addr_a = '0;
    logic [31:0] data_a = '0;
    logic        done_a, pass_a, fail_a, to_a;
    logic [0:0]  fm_a;
    logic [31:0] cnt_a;

    // Instance B: two harts
    logic        rst_b = 1'b1;
    logic [1:0]  we_b = '0;
    logic [9:0]  addr_b = '0;
    logic [63:0] data_b = '0;
    logic        done_b, pass_b, fail_b, to_b;
    logic [1:0]  fm_b;
    logic [31:0] cnt_b;

    // Instance C: one hart, TIMEOUT_CYCLES=100
    logic        rst_c = 1'b1;
    logic [0:0]  we_c = '0;
    logic [4:0]  addr_c = '0;
    logic [31:0] data_c = '0;
    logic        done_c, pass_c, fail_c, to_c;
    logic [0:0]  fm_c;
    logic [31:0] cnt_c;

    sim_test_monitor u_dut_a (
        .clk(clk), .rst(rst_a), .wb_we(we_a), .wb_addr(addr_a), .wb_data(data_a),
        .done(done_a), .pass(pass_a), .fail(fail_a), .timeout(to_a),
        .fail_mask(fm_a), .cycle_cnt(cnt_a)
    );

    sim_test_monitor #(.NUM_HARTS(2)) u_dut_b (
        .clk(clk), .rst(rst_b), .wb_we(we_b), .wb_addr(addr_b), .wb_data(data_b),
        .done(done_b), .pass(pass_b), .fail(fail_b), .timeout(to_b),
        .fail_mask(fm_b), .cycle_cnt(cnt_b)
    );

    sim_test_monitor #(.TIMEOUT_CYCLES(100)) u_dut_c (
        .clk(clk), .rst(rst_c), .wb_we(we_c), .wb_addr(addr_c), .wb_data(data_c),
        .done(done_c), .pass(pass_c), .fail(fail_c), .timeout(to_c),
        .fail_mask(fm_c), .cycle_cnt(cnt_c)
    );

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic wait_cycle(input int unsigned n);
        while (cyc < n) step();
    endtask

    // One-cycle reset pulse; afterwards the bench sits in cycle 0.
    task automatic reset_dut(input int sel);
        case (sel)
            0: rst_a = 1'b1;
            1: rst_b = 1'b1;
            default: rst_c = 1'b1;
        endcase
        @(posedge clk);
        #1;
        rst_a = 1'b0;
        rst_b = 1'b0;
        rst_c = 1'b0;
        cyc = 0;
    endtask

    task automatic wr_a(input logic [4:0] a, input logic [31:0] d);
        we_a = 1'b1; addr_a = a; data_a = d;
        step();
        we_a = 1'b0; addr_a = '0; data_a = '0;
    endtask

    task automatic wr_b(input int h, input logic [4:0] a, input logic [31:0] d);
        we_b[h] = 1'b1; addr_b[5*h +: 5] = a; data_b[32*h +: 32] = d;
        step();
        we_b = '0; addr_b = '0; data_b = '0;
    endtask

    task automatic wr_c(input logic [4:0] a, input logic [31:0] d);
        we_c = 1'b1; addr_c = a; data_c = d;
        step();
        we_c = 1'b0; addr_c = '0; data_c = '0;
    endtask

    task automatic check_a(input string tag, input logic d, input logic p, input logic f,
                           input logic t, input logic [0:0] m);
        check({tag, " done"}, done_a, d);
        check({tag, " pass"}, pass_a, p);
        check({tag, " fail"}, fail_a, f);
        check({tag, " timeout"}, to_a, t);
        check({tag, " fail_mask"}, fm_a, m);
    endtask

    initial begin
        // Test 1 + x0 writes: pass flow on instance A
        reset_dut(0);
        check_a("t1 reset", 0, 0, 0, 0, 1'b0);
        check("t1 reset cycle_cnt", cnt_a, 0);
        wait_cycle(2);
        wr_a(5'd0, 32'd1);
        wr_a(5'd0, 32'd1);
        wait_cycle(12);
        check("x0 ignored done", done_a, 0);
        check("t1 cycle_cnt@12", cnt_a, 12);
        wait_cycle(20);
        wr_a(5'd27, 32'd1);
        wait_cycle(30);
        wr_a(5'd26, 32'd1);
        wait_cycle(35);
        check("t1 done@35", done_a, 0);
        step();
        check_a("t1 end", 1, 1, 0, 0, 1'b0);
        check("t1 cycle_cnt@36", cnt_a, 36);
        wait_cycle(40);
        check("t1 cycle_cnt frozen", cnt_a, 36);

        // Reset while in END
        reset_dut(0);
        check_a("rst in END", 0, 0, 0, 0, 1'b0);
        check("rst in END cycle_cnt", cnt_a, 0);
        step();
        check("rst in END cycle_cnt+1", cnt_a, 1);

        // Test 2: result overwritten inside DRAIN
        reset_dut(0);
        wait_cycle(9);
        wr_a(5'd27, 32'd1);
        wr_a(5'd26, 32'd1);
        wait_cycle(13);
        wr_a(5'd27, 32'd0);
        wait_cycle(15);
        check("t2 done@15", done_a, 0);
        step();
        check_a("t2 end", 1, 0, 1, 0, 1'b1);

        // Reset while in DRAIN (DRAIN spans cycles 4..8)
        reset_dut(0);
        wait_cycle(3);
        wr_a(5'd26, 32'd1);
        wait_cycle(5);
        reset_dut(0);
        check_a("rst in DRAIN", 0, 0, 0, 0, 1'b0);
        check("rst in DRAIN cycle_cnt", cnt_a, 0);
        wait_cycle(10);
        check("rst in DRAIN no done", done_a, 0);
        check("rst in DRAIN cycle_cnt@10", cnt_a, 10);

        // Test 3: two harts, hart1 fails, DONE value 2 ignored
        reset_dut(1);
        check("t3 reset done", done_b, 0);
        wait_cycle(4);
        wr_b(0, 5'd27, 32'd1);
        wr_b(0, 5'd26, 32'd1);
        wait_cycle(20);
        wr_b(1, 5'd26, 32'd2);
        wait_cycle(30);
        check("t3 done=2 ignored", done_b, 0);
        wait_cycle(39);
        wr_b(1, 5'd27, 32'd3);
        wr_b(1, 5'd26, 32'd1);
        wait_cycle(45);
        check("t3 done@45", done_b, 0);
        step();
        check("t3 done", done_b, 1);
        check("t3 pass", pass_b, 0);
        check("t3 fail", fail_b, 1);
        check("t3 timeout", to_b, 0);
        check("t3 fail_mask", fm_b, 2'b10);

        // Test 4a: timeout with no DONE write
        reset_dut(2);
        wait_cycle(99);
        check("t4a done@99", done_c, 0);
        step();
        check("t4a done", done_c, 1);
        check("t4a timeout", to_c, 1);
        check("t4a fail", fail_c, 1);
        check("t4a pass", pass_c, 0);
        check("t4a cycle_cnt", cnt_c, 100);
        check("t4a fail_mask", fm_c, 1'b1);
        wait_cycle(110);
        check("t4a cycle_cnt frozen", cnt_c, 100);

        // Test 4b: DONE in the last RUN cycle beats the timeout
        reset_dut(2);
        wait_cycle(99);
        wr_c(5'd26, 32'd1);
        check("t4b done@100", done_c, 0);
        check("t4b timeout@100", to_c, 0);
        wait_cycle(105);
        check("t4b done", done_c, 1);
        check("t4b timeout", to_c, 0);
        check("t4b fail", fail_c, 1);
        check("t4b fail_mask", fm_c, 1'b1);
        check("t4b cycle_cnt", cnt_c, 105);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
